// File: rtl/bp_pkg.sv
// Shared types and helpers for the IF-stage branch predictor and its BHT.
package bp_pkg;

  typedef enum logic [2:0] {
    BR_EQ   = 3'd0,
    BR_NE   = 3'd1,
    BR_NONE = 3'd2,
    BR_JUMP = 3'd3,
    BR_LT   = 3'd4,
    BR_GE   = 3'd5,
    BR_LTU  = 3'd6,
    BR_GEU  = 3'd7
  } br_type_e;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } bp_state_e;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  function automatic logic is_cond(input logic [2:0] br_type);
    return (br_type != BR_NONE) && (br_type != BR_JUMP);
  endfunction

  // Saturating 2-bit counter step toward the resolved outcome.
  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    nxt = ctr;
    if (taken && ctr != CTR_ST)        nxt = ctr + 2'd1;
    else if (!taken && ctr != CTR_SNT) nxt = ctr - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/bht_array.sv
// Branch history table: 2**IDX_BITS x 2-bit counters, one async read port and one
// sync write port that either loads the init value or applies a saturating train step.
module bht_array
  import bp_pkg::*;
#(
  parameter int IDX_BITS = 6
) (
  input  logic                clk,
  input  logic [IDX_BITS-1:0] rd_idx,
  output logic [1:0]          rd_ctr,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic                wr_init,
  input  logic                wr_taken
);

  localparam int DEPTH = 1 << IDX_BITS;

  // No reset on the storage: the post-reset init walk clears every entry.
  logic [1:0] mem_q [DEPTH];
  logic [1:0] ctr_d;

  assign rd_ctr = mem_q[rd_idx];

  always_comb begin
    ctr_d = ctr_update(mem_q[wr_idx], wr_taken);
    if (wr_init) ctr_d = CTR_WNT;
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= ctr_d;
  end

endmodule

// File: rtl/branch_predictor.sv
// IF-stage dynamic branch predictor with EX-stage training and mispredict redirect.
// Optional BP_STATS_EN adds saturating branch / mispredict counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int IDX_BITS = 6,
  parameter int XLEN     = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  input  logic [2:0]      if_br_type,
  input  logic [XLEN-1:0] if_target,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_pc,
  output logic            init_busy,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [2:0]      ex_br_type,
  input  logic            ex_br_taken,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  localparam logic [IDX_BITS-1:0] LAST_IDX = '1;

  bp_state_e             state_q, state_d;
  logic [IDX_BITS-1:0]   init_idx_q, init_idx_d;
  logic [IDX_BITS-1:0]   if_idx, ex_idx, wr_idx;
  logic [1:0]            if_ctr;
  logic                  wr_en, wr_init;
  logic                  run, ex_cond;

  assign if_idx  = if_pc[IDX_BITS+1:2];
  assign ex_idx  = ex_pc[IDX_BITS+1:2];
  assign ex_cond = ex_valid & is_cond(ex_br_type);

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    wr_en      = 1'b0;
    wr_init    = 1'b0;
    wr_idx     = ex_idx;
    case (state_q)
      INIT: begin
        wr_en      = 1'b1;
        wr_init    = 1'b1;
        wr_idx     = init_idx_q;
        init_idx_d = init_idx_q + 1'b1;
        if (init_idx_q == LAST_IDX) state_d = RUN;
      end
      RUN: wr_en = ex_cond;
    endcase
    // A reset cycle must not commit a training write from a stale RUN state.
    if (rst) wr_en = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      init_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
    end
  end

  bht_array #(.IDX_BITS(IDX_BITS)) u_bht (
    .clk      (clk),
    .rd_idx   (if_idx),
    .rd_ctr   (if_ctr),
    .wr_en    (wr_en),
    .wr_idx   (wr_idx),
    .wr_init  (wr_init),
    .wr_taken (ex_br_taken)
  );

  // Reset is treated like INIT on the outputs so nothing escapes while state_q is stale.
  assign init_busy = rst | (state_q == INIT);
  assign run       = ~init_busy;

  always_comb begin
    pred_taken  = run & ((if_br_type == BR_JUMP) |
                         (is_cond(if_br_type) & (if_ctr >= CTR_WT)));
    pred_pc     = pred_taken ? if_target : if_pc + XLEN'(4);
    mispredict  = run & ex_valid & (ex_br_type != BR_NONE) & (ex_br_taken != ex_pred_taken);
    redirect_pc = ex_br_taken ? ex_target : ex_pc + XLEN'(4);
  end

`ifdef BP_STATS_EN
  logic [31:0] stat_br_q, stat_br_d, stat_mp_q, stat_mp_d;

  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (run & ex_cond & (stat_br_q != 32'hFFFF_FFFF)) stat_br_d = stat_br_q + 32'd1;
    if (mispredict & (stat_mp_q != 32'hFFFF_FFFF))    stat_mp_d = stat_mp_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches    = stat_br_q;
  assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized bench for branch_predictor against an array-of-counters reference model.
module tb_branch_predictor;
  import bp_pkg::*;

  localparam int N = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_pc = '0, if_target = '0, ex_pc = '0, ex_target = '0;
  logic [2:0]  if_br_type = 3'd2, ex_br_type = 3'd2;
  logic        ex_valid = 1'b0, ex_br_taken = 1'b0, ex_pred_taken = 1'b0;
  logic        pred_taken, init_busy, mispredict;
  logic [31:0] pred_pc, redirect_pc;
`ifdef BP_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  always #5 clk = ~clk;

  branch_predictor #(.IDX_BITS(6), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .if_pc(if_pc), .if_br_type(if_br_type), .if_target(if_target),
    .pred_taken(pred_taken), .pred_pc(pred_pc), .init_busy(init_busy),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_br_type(ex_br_type),
    .ex_br_taken(ex_br_taken), .ex_pred_taken(ex_pred_taken), .ex_target(ex_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc)
`ifdef BP_STATS_EN
    , .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
`endif
  );

  // Reference model: one integer counter per table entry plus remaining busy cycles.
  int m_ctr [N];
  int m_busy = N;
  int m_br = 0, m_mp = 0;
  bit chk_en = 1'b0;
  int n_vec = 0, n_err = 0;

  function automatic bit cond_t(input logic [2:0] t);
    return (t != 3'd2) && (t != 3'd3);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= N;
      m_br   <= 0;
      m_mp   <= 0;
      for (int i = 0; i < N; i++) m_ctr[i] <= 1;
    end else if (m_busy > 0) begin
      m_busy <= m_busy - 1;
    end else if (ex_valid) begin
      if (cond_t(ex_br_type)) begin
        m_br <= m_br + 1;
        if (ex_br_taken) m_ctr[ex_pc[7:2]] <= (m_ctr[ex_pc[7:2]] == 3) ? 3 : m_ctr[ex_pc[7:2]] + 1;
        else             m_ctr[ex_pc[7:2]] <= (m_ctr[ex_pc[7:2]] == 0) ? 0 : m_ctr[ex_pc[7:2]] - 1;
      end
      if (ex_br_type != 3'd2 && ex_br_taken != ex_pred_taken) m_mp <= m_mp + 1;
    end
  end

  always @(negedge clk) begin
    bit          busy_e, pt_e, mp_e;
    logic [31:0] ppc_e, rpc_e;
    if (chk_en) begin
      busy_e = rst || (m_busy > 0);
      pt_e   = !busy_e && ((if_br_type == 3'd3) ||
                           (cond_t(if_br_type) && m_ctr[if_pc[7:2]] >= 2));
      ppc_e  = pt_e ? if_target : if_pc + 32'd4;
      mp_e   = !busy_e && ex_valid && ex_br_type != 3'd2 && ex_br_taken != ex_pred_taken;
      rpc_e  = ex_br_taken ? ex_target : ex_pc + 32'd4;
      chk("init_busy", {31'd0, init_busy}, {31'd0, busy_e});
      chk("pred_taken", {31'd0, pred_taken}, {31'd0, pt_e});
      chk("pred_pc", pred_pc, ppc_e);
      chk("mispredict", {31'd0, mispredict}, {31'd0, mp_e});
      chk("redirect_pc", redirect_pc, rpc_e);
`ifdef BP_STATS_EN
      chk("stat_branches", stat_branches, m_br);
      chk("stat_mispredicts", stat_mispredicts, m_mp);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0; ex_br_type = 3'd2; if_br_type = 3'd2;
  endtask

  task automatic ex_drive(input logic [31:0] pc, input logic [2:0] t, input logic tk,
                          input logic pt, input logic [31:0] tgt);
    ex_valid = 1'b1; ex_pc = pc; ex_br_type = t;
    ex_br_taken = tk; ex_pred_taken = pt; ex_target = tgt;
  endtask

  task automatic count_walk(input string nm);
    int cnt = 0;
    while (init_busy && cnt < 300) begin
      cnt++;
      step();
    end
    chk(nm, cnt, 64);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    count_walk("walk_len");
  endtask

  initial begin
    step();
    chk("busy_in_rst", {31'd0, init_busy}, 32'd1);
    chk("pred_in_rst", {31'd0, pred_taken}, 32'd0);
    step();
    rst = 1'b0;
    chk_en = 1'b1;
    count_walk("walk_len_first");

    // Every entry starts weakly-not-taken: one taken step flips it to predict taken.
    for (int i = 0; i < N; i++) begin
      if_pc = 32'(i * 4); if_br_type = 3'd0; if_target = 32'h8000_0000 + 32'(i);
      ex_drive(32'(i * 4), 3'd0, 1'b1, 1'b0, 32'h0);
      #1;
      chk("sweep_pre", {31'd0, pred_taken}, 32'd0);
      step();
      ex_valid = 1'b0;
      #1;
      chk("sweep_post", {31'd0, pred_taken}, 32'd1);
    end
    idle();

    // Saturation on one entry.
    do_reset();
    if_pc = 32'h40; if_br_type = 3'd0; if_target = 32'h1234;
    ex_drive(32'h40, 3'd0, 1'b1, 1'b1, 32'h1234);
    step(); step();
    ex_valid = 1'b0;
    #1;
    chk("sat_pt2", {31'd0, pred_taken}, 32'd1);
    chk("sat_pc2", pred_pc, 32'h1234);
    ex_valid = 1'b1;
    step();
    ex_br_taken = 1'b0;
    step(); step(); step();
    #1;
    chk("sat_pt_3nt", {31'd0, pred_taken}, 32'd0);
    step();
    ex_valid = 1'b0;
    #1;
    chk("sat_pt_4nt", {31'd0, pred_taken}, 32'd0);
    chk("sat_pc_4nt", pred_pc, 32'h44);
    // An entry at 2'b11 needs two not-takens to predict not-taken; at 2'b00 one taken stays 0.
    ex_drive(32'h40, 3'd0, 1'b1, 1'b0, 32'h1234);
    step();
    ex_valid = 1'b0;
    #1;
    chk("floor_pt", {31'd0, pred_taken}, 32'd0);

    // Redirect targets.
    ex_drive(32'h100, 3'd1, 1'b1, 1'b0, 32'h200);
    #1;
    chk("mp_tk", {31'd0, mispredict}, 32'd1);
    chk("rd_tk", redirect_pc, 32'h200);
    ex_drive(32'h100, 3'd1, 1'b0, 1'b1, 32'h200);
    #1;
    chk("mp_nt", {31'd0, mispredict}, 32'd1);
    chk("rd_nt", redirect_pc, 32'h104);
    ex_drive(32'h100, 3'd3, 1'b1, 1'b1, 32'h300);
    #1;
    chk("mp_jmp_ok", {31'd0, mispredict}, 32'd0);
    step();

    // Same-cycle read/write of idx 5: no bypass.
    do_reset();
    if_pc = 32'h14; if_br_type = 3'd4; if_target = 32'hABC0;
    ex_drive(32'h14, 3'd4, 1'b1, 1'b0, 32'hABC0);
    #1;
    chk("bypass_old", {31'd0, pred_taken}, 32'd0);
    step();
    ex_valid = 1'b0;
    #1;
    chk("bypass_new", {31'd0, pred_taken}, 32'd1);

    // Wrap-around of PC+4.
    if_pc = 32'hFFFF_FFFC; if_br_type = 3'd2;
    ex_drive(32'hFFFF_FFFC, 3'd5, 1'b0, 1'b0, 32'h0);
    #1;
    chk("wrap_pred", pred_pc, 32'h0);
    chk("wrap_redir", redirect_pc, 32'h0);
    step();
    idle();

    // Reset mid-walk; EX training during the walk is dropped.
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (30) step();
    rst = 1'b1;
    ex_drive(32'h14, 3'd0, 1'b1, 1'b0, 32'h0);
    step();
    rst = 1'b0;
    count_walk("walk_restart");
    ex_valid = 1'b0;
    if_pc = 32'h14; if_br_type = 3'd0;
    #1;
    chk("walk_drop_ex", {31'd0, pred_taken}, 32'd0);

    // Random traffic with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      rst           = ($urandom_range(0, 499) == 0);
      if_pc         = ($urandom & 32'h0000_00FF) | (($urandom_range(0, 3) == 0) ? 32'hFFFF_FF00 : 32'h0);
      if_br_type    = 3'($urandom_range(0, 7));
      if_target     = $urandom;
      ex_valid      = ($urandom_range(0, 3) != 0);
      ex_pc         = ($urandom & 32'h0000_00FF);
      ex_br_type    = 3'($urandom_range(0, 7));
      ex_br_taken   = 1'($urandom_range(0, 1));
      ex_pred_taken = 1'($urandom_range(0, 1));
      ex_target     = $urandom;
      step();
    end
    rst = 1'b0;
    idle();
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
